// File: rtl/add8_rr_arbiter.sv
// add8_rr_arbiter: round-robin arbiter plus two-stage pipeline in front of a
// shared combinational 8-bit adder core.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   req_valid/_a/_b per-requester operand handshake, operands packed 8 bits each
//   req_ready       one-hot grant (zero when the operand stage cannot take)
//   add_a/add_b     registered operands to the shared core
//   add_o           combinational {carry, sum} from the core
//   res_valid/_sum/_id/_ready  tagged result handshake
//   busy            any operation in flight
//   op_cnt          wrapping count of accepted operations
module add8_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_a,
   input  logic [8*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         add_a,
   output logic [7:0]         add_b,
   input  logic [8:0]         add_o,
   output logic               res_valid,
   output logic [8:0]         res_sum,
   output logic [ID_W-1:0]    res_id,
   input  logic               res_ready,
   output logic               busy,
   output logic [15:0]        op_cnt
);

   // Operand stage (S1)
   logic [7:0]      op_a_q, op_a_d;
   logic [7:0]      op_b_q, op_b_d;
   logic [ID_W-1:0] op_id_q, op_id_d;
   logic            s1_valid_q, s1_valid_d;
   // Result stage (S2)
   logic [8:0]      res_sum_q, res_sum_d;
   logic [ID_W-1:0] res_id_q, res_id_d;
   logic            res_valid_q, res_valid_d;
   // Arbitration pointer (last accepted requester) and op counter
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [15:0]     op_cnt_q, op_cnt_d;

   logic            s2_free;
   logic            adv;
   logic            s1_take;
   logic            found;
   logic [ID_W-1:0] grant_id;
   int unsigned     idx;

   assign s2_free = !res_valid_q || res_ready;
   assign adv     = s1_valid_q && s2_free;
   assign s1_take = !s1_valid_q || adv;

   // Search ptr+1, ptr+2, ... modulo N_REQ; first valid requester wins.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      idx      = 0;
      if (s1_take && !rst) begin
         for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
               found    = 1'b1;
               grant_id = idx[ID_W-1:0];
            end
         end
      end
   end

   assign req_ready = found ? (N_REQ'(1) << grant_id) : '0;

   always_comb begin
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      s1_valid_d  = s1_valid_q;
      res_sum_d   = res_sum_q;
      res_id_d    = res_id_q;
      res_valid_d = res_valid_q;
      ptr_d       = ptr_q;
      op_cnt_d    = op_cnt_q;

      // S2 takes the old S1 contents on the same edge S1 may reload.
      if (adv) begin
         res_sum_d   = add_o;
         res_id_d    = op_id_q;
         res_valid_d = 1'b1;
      end else if (s2_free) begin
         res_valid_d = 1'b0;
      end

      if (s1_take) begin
         s1_valid_d = found;
         if (found) begin
            op_a_d   = req_a[8*grant_id +: 8];
            op_b_d   = req_b[8*grant_id +: 8];
            op_id_d  = grant_id;
            ptr_d    = grant_id;
            op_cnt_d = op_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= '0;
         s1_valid_q  <= 1'b0;
         res_sum_q   <= '0;
         res_id_q    <= '0;
         res_valid_q <= 1'b0;
         ptr_q       <= ID_W'(N_REQ - 1);
         op_cnt_q    <= '0;
      end else begin
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         s1_valid_q  <= s1_valid_d;
         res_sum_q   <= res_sum_d;
         res_id_q    <= res_id_d;
         res_valid_q <= res_valid_d;
         ptr_q       <= ptr_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign add_a     = op_a_q;
   assign add_b     = op_b_q;
   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_id    = res_id_q;
   assign busy      = s1_valid_q || res_valid_q;
   assign op_cnt    = op_cnt_q;

endmodule

// File: doc/add8_rr_arbiter.md
# add8_rr_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one combinational 8-bit adder core (A[7:0], B[7:0] -> O[8:0], exact or approximate) among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, drives the shared core from a registered operand stage, and returns the 9-bit result tagged with the requester index over a single valid/ready result port. The block sits between accelerator lanes and the adder core, so any adder variant can be bound at integration without changing the lanes.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, tag width; must equal ceil(log2(N_REQ)), minimum 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_a  in  8*N_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*N_REQ  operand B; same packing as req_a.
- req_ready  out  N_REQ  one-hot or zero; grant/accept strobe.
- add_a  out  8  operand A to the shared adder core (registered).
- add_b  out  8  operand B to the shared adder core (registered).
- add_o  in  9  combinational sum from the core, {carry, sum[7:0]}.
- res_valid  out  1  result valid.
- res_sum  out  9  captured add_o.
- res_id  out  ID_W  index of the originating requester.
- res_ready  in  1  result consumer ready.
- busy  out  1  s1_valid | res_valid.
- op_cnt  out  16  count of accepted operations; wraps from 0xFFFF to 0.

## Operation
- Stage S1: registers op_a, op_b, op_id, and s1_valid. add_a = op_a and add_b = op_b at all times, including when s1_valid=0.
- Stage S2: registers res_sum, res_id, and res_valid.
- s2_free = !res_valid | res_ready.
- adv = s1_valid & s2_free. On adv, S2 loads {add_o, op_id} and res_valid is set.
- If s2_free and !s1_valid, res_valid clears at the next edge.
- s1_take = !s1_valid | adv.
- Arbitration is combinational, evaluated only when s1_take=1:
  - Search requesters ptr+1, ptr+2, … modulo N_REQ.
  - The first one with req_valid=1 gets req_ready=1.
  - When s1_take=0, req_ready is all zero.
- Acceptance occurs when req_valid[i] & req_ready[i] at an edge. On acceptance:
  - S1 loads the operands of requester i.
  - op_id is set to i and s1_valid to 1.
  - ptr is set to i and op_cnt increments.
- If s1_take=1 with no request, s1_valid clears. ptr changes only on acceptance.
- Requesters must hold req_a/req_b stable while req_valid=1 until accepted. The block does not check this.
- Fairness: a continuously asserted requester is accepted within N_REQ acceptances.
- Arithmetic:
  - res_sum is add_o verbatim; no correction or check against an exact sum.
  - The carry is bit 8.
  - No width extension beyond 9 bits.
- Simultaneous adv and acceptance in one cycle is legal: S2 takes the old S1 contents while S1 loads the new operands. This gives full throughput.
- Backpressure: with res_ready=0 and res_valid=1, S2 holds. S1 holds once filled, and req_ready then drops to zero. Maximum occupancy is 2 operations.
- Reset:
  - s1_valid=0, res_valid=0, op_a=op_b=0, op_id=0, res_sum=0, res_id=0, op_cnt=0.
  - ptr=N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation discards all in-flight operations without emitting results. req_ready is all zero while rst=1.

## Timing
- Reset values of all outputs: req_ready=0, add_a=0, add_b=0, res_valid=0, res_sum=0, res_id=0, busy=0, op_cnt=0.
- Latency: accept at edge t puts add_a/add_b valid after t. The result registers at edge t+1 if S2 is free, so res_valid=1 in the cycle after edge t+1.
- Throughput: one operation per cycle with res_ready held at 1.
- The add_o path is single-cycle: core delay plus S2 setup must fit one clk period.
- req_ready depends combinationally on req_valid, res_ready, and state; there is no combinational path from add_o to any output.
- The result handshake completes at an edge with res_valid & res_ready. res_sum/res_id are stable while res_valid=1 and res_ready=0.

## Test plan
- Single op, bench core exact: after reset, req 2 presents a=0x7F, b=0x81 -> req_ready=0b0100 in the same cycle. Two cycles later res_valid=1, res_sum=0x100, res_id=2, op_cnt=1.
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> acceptance order 0,1,2,3,0,1 and one result per cycle after a 2-cycle fill.
- Backpressure: res_ready=0 with requests pending -> exactly 2 acceptances, then req_ready=0. res_sum/res_id stay stable. Releasing res_ready drains results in order.
- Approximate core bound: the bench returns add_o = (a+b) ^ 9'h010 -> res_sum equals the corrupted value bit-exactly and res_id stays correct.
- Reset mid-operation: assert rst with S1 and S2 full -> next cycle res_valid=0, busy=0, op_cnt=0. The first grant after reset goes to requester 0.
- Counter wrap: 65536 accepted operations -> op_cnt returns to 0, and arbitration and results are unaffected.
